// File: rtl/circuit_test_sequencer.sv
// Truth-table sweep of a 1-output CUT: apply, settle, multi-sample, score.
// Ports: clk, rst, start, abort, expected, cut_out in; cut_in, busy, done, pass, counts out.
module circuit_test_sequencer #(
  parameter int IN_WIDTH      = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_COUNT  = 4,
  parameter int NUM_TRIALS    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [2**IN_WIDTH-1:0] expected,
  output logic [IN_WIDTH-1:0]    cut_in,
  input  logic                   cut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            mismatch_count,
  output logic [15:0]            unstable_count
);

  localparam int CMAX = (SETTLE_CYCLES > SAMPLE_COUNT) ?
                        SETTLE_CYCLES : SAMPLE_COUNT;
  localparam int CW   = $clog2(CMAX);
  localparam int TW   = (NUM_TRIALS > 1) ? $clog2(NUM_TRIALS) : 1;

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]       cnt;
  logic [IN_WIDTH-1:0] vector;
  logic [TW-1:0]       trial;
  logic                sync1, sync2;
  logic                smp0, eq;
  logic                last_settle, last_sample;
  logic                last_vec, last_trial;
  logic                all_eq, kill;

  assign last_settle = (cnt == CW'(SETTLE_CYCLES - 1));
  assign last_sample = (cnt == CW'(SAMPLE_COUNT - 1));
  assign last_vec    = (vector == {IN_WIDTH{1'b1}});
  assign last_trial  = (trial == TW'(NUM_TRIALS - 1));
  // current sync2 is the final sample, so fold it in here
  assign all_eq      = eq & (sync2 == smp0);
  assign kill        = abort & (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (kill) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state_nx = APPLY;
        APPLY:   state_nx = SETTLE;
        SETTLE:  if (last_settle) state_nx = SAMPLE;
        SAMPLE:  if (last_sample) state_nx = NEXT;
        NEXT:    state_nx = (last_vec && last_trial) ?
                            DONE : APPLY;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cut_in         <= '0;
      vector         <= '0;
      trial          <= '0;
      cnt            <= '0;
      sync1          <= 1'b0;
      sync2          <= 1'b0;
      smp0           <= 1'b0;
      eq             <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      unstable_count <= '0;
    end else begin
      sync1 <= cut_out;
      sync2 <= sync1;
      // dwell counter restarts on every state change
      if (state_nx != state ||
          !(state == SETTLE || state == SAMPLE))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (kill) begin
        cut_in <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              mismatch_count <= '0;
              unstable_count <= '0;
              pass           <= 1'b0;
              vector         <= '0;
              trial          <= '0;
            end
          end
          APPLY: cut_in <= vector;
          SAMPLE: begin
            if (cnt == '0) begin
              smp0 <= sync2;
              eq   <= 1'b1;
            end else begin
              eq <= all_eq;
            end
            if (last_sample) begin
              if (!all_eq) begin
                if (unstable_count != 16'hFFFF)
                  unstable_count <= unstable_count + 16'd1;
              end else if (smp0 != expected[vector]) begin
                if (mismatch_count != 16'hFFFF)
                  mismatch_count <= mismatch_count + 16'd1;
              end
            end
          end
          NEXT: begin
            if (last_vec) begin
              vector <= '0;
              if (last_trial)
                // visible together with the done pulse
                pass <= (mismatch_count == '0) &&
                        (unstable_count == '0);
              else
                trial <= trial + 1'b1;
            end else begin
              vector <= vector + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
